// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, frame size
// and the default slave address used by master and slave.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    STOP,
    DONE
  } i2c_state_t;

  localparam int         I2C_NUM_BYTES  = 5;
  localparam logic [6:0] I2C_SLAVE_ADDR = 7'h55;

endpackage

// File: rtl/i2c_phase_timer.sv
// Quarter-SCL phase divider: one-clk phase_tick every SCL_DIV clk.
// Ports: clk, reset (async high), clear (restart count), phase_tick.
module i2c_phase_timer
#(
  parameter int SCL_DIV = 250
)
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic phase_tick
);

  localparam int W = (SCL_DIV > 1) ? $clog2(SCL_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(SCL_DIV - 1);

  logic [W-1:0] cnt;

  assign phase_tick = (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clear || phase_tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/i2c_master_tx.sv
// Write-only I2C master: START, {addr,W}, 5 data bytes with ACK slots, STOP.
// Ports: clk, reset (async high), start, tx_data0..4, i2c_scl, i2c_sda
// (open-drain), busy, done, ack_err. Macro I2C_MASTER_ACK_CHECK_EN
// enables NACK detection (sets ack_err and aborts to STOP).
module i2c_master_tx
  import i2c_pkg::*;
#(
  parameter int         SCL_DIV    = 250,
  parameter logic [6:0] SLAVE_ADDR = I2C_SLAVE_ADDR
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_data0,
  input  logic [7:0] tx_data1,
  input  logic [7:0] tx_data2,
  input  logic [7:0] tx_data3,
  input  logic [7:0] tx_data4,
  output logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  i2c_state_t state;
  logic [1:0] ph;
  logic [2:0] bit_cnt;
  logic [2:0] byte_idx;
  logic [7:0] sh;
  logic [4:0][7:0] shadow;
  logic sda_low;
  logic phase_tick;
  logic accept;
  logic [2:0] nxt_byte;
  logic last_byte;
  logic stop_now;

  assign accept = (state == IDLE) && start;
  assign i2c_sda = sda_low ? 1'b0 : 1'bz;

  assign nxt_byte  = (state == ADDR_ACK) ? 3'd0 : byte_idx + 3'd1;
  assign last_byte = (state == DATA_ACK) &&
                     (byte_idx == 3'(I2C_NUM_BYTES - 1));

  i2c_phase_timer #(.SCL_DIV(SCL_DIV)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept),
    .phase_tick (phase_tick)
  );

`ifdef I2C_MASTER_ACK_CHECK_EN
  logic [1:0] sda_sync;
  logic nack;
  logic ack_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sda_sync <= 2'b11;
    else
      sda_sync <= {sda_sync[0], i2c_sda};
  end

  assign ack_err  = ack_err_q;
  assign stop_now = last_byte || nack;
`else
  assign ack_err  = 1'b0;
  assign stop_now = last_byte;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ph       <= 2'd0;
      bit_cnt  <= 3'd0;
      byte_idx <= 3'd0;
      sh       <= 8'd0;
      shadow   <= '0;
      sda_low  <= 1'b0;
      i2c_scl  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef I2C_MASTER_ACK_CHECK_EN
      nack      <= 1'b0;
      ack_err_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shadow  <= {tx_data4, tx_data3, tx_data2,
                        tx_data1, tx_data0};
            sh      <= {SLAVE_ADDR, 1'b0};
            busy    <= 1'b1;
            state   <= START;
            ph      <= 2'd0;
            sda_low <= 1'b1;
            i2c_scl <= 1'b1;
`ifdef I2C_MASTER_ACK_CHECK_EN
            nack      <= 1'b0;
            ack_err_q <= 1'b0;
`endif
          end
        end
        START: begin
          if (phase_tick) begin
            if (ph == 2'd0) begin
              ph      <= 2'd1;
              i2c_scl <= 1'b0;
            end else begin
              state   <= ADDR;
              ph      <= 2'd0;
              bit_cnt <= 3'd7;
              sda_low <= ~sh[7];
            end
          end
        end
        ADDR, DATA: begin
          if (phase_tick) begin
            ph <= ph + 2'd1;
            unique case (ph)
              2'd0: i2c_scl <= 1'b1;
              2'd2: i2c_scl <= 1'b0;
              2'd3: begin
                if (bit_cnt == 3'd0) begin
                  state   <= (state == ADDR) ? ADDR_ACK : DATA_ACK;
                  sda_low <= 1'b0;
                end else begin
                  bit_cnt <= bit_cnt - 3'd1;
                  sh      <= {sh[6:0], 1'b0};
                  sda_low <= ~sh[6];
                end
              end
              default: ;
            endcase
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (phase_tick) begin
            ph <= ph + 2'd1;
            unique case (ph)
              2'd0: i2c_scl <= 1'b1;
              2'd2: begin
                i2c_scl <= 1'b0;
`ifdef I2C_MASTER_ACK_CHECK_EN
                nack <= sda_sync[1];
`endif
              end
              2'd3: begin
`ifdef I2C_MASTER_ACK_CHECK_EN
                if (nack)
                  ack_err_q <= 1'b1;
`endif
                if (stop_now) begin
                  state   <= STOP;
                  sda_low <= 1'b1;
                end else begin
                  state    <= DATA;
                  byte_idx <= nxt_byte;
                  bit_cnt  <= 3'd7;
                  sh       <= shadow[nxt_byte];
                  sda_low  <= ~shadow[nxt_byte][7];
                end
              end
              default: ;
            endcase
          end
        end
        STOP: begin
          if (phase_tick) begin
            unique case (ph)
              2'd0: begin
                ph      <= 2'd1;
                i2c_scl <= 1'b1;
              end
              2'd1: begin
                ph      <= 2'd2;
                sda_low <= 1'b0;
              end
              default: state <= DONE;
            endcase
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          ph    <= 2'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_tx.sv
// Directed bench for i2c_master_tx with a behavioural slave at 0x55.
// Checks bytes on the bus, done timing, START/STOP count, NACK and reset.
module tb_i2c_master_tx;

  localparam int DIV   = 4;
  localparam int FULL  = 221 * DIV + 1;
  localparam int SHORT = 41 * DIV + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [7:0] tx_data0 = 8'h0;
  logic [7:0] tx_data1 = 8'h0;
  logic [7:0] tx_data2 = 8'h0;
  logic [7:0] tx_data3 = 8'h0;
  logic [7:0] tx_data4 = 8'h0;
  logic i2c_scl;
  wire  i2c_sda;
  logic busy;
  logic done;
  logic ack_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_b [5];

  always #5 clk = ~clk;

  i2c_master_tx #(.SCL_DIV(DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .tx_data0 (tx_data0),
    .tx_data1 (tx_data1),
    .tx_data2 (tx_data2),
    .tx_data3 (tx_data3),
    .tx_data4 (tx_data4),
    .i2c_scl  (i2c_scl),
    .i2c_sda  (i2c_sda),
    .busy     (busy),
    .done     (done),
    .ack_err  (ack_err)
  );

  logic ack_drv = 1'b0;
  logic sda_v;
  pullup (i2c_sda);
  assign i2c_sda = ack_drv ? 1'b0 : 1'bz;
  assign sda_v = (i2c_sda === 1'b0) ? 1'b0 : 1'b1;

  logic ps = 1'b1;
  logic pd = 1'b1;
  logic in_ack = 1'b0;
  logic [7:0] sr = 8'h0;
  int bcnt = 0;
  int nbytes = 0;
  int starts = 0;
  int stops = 0;
  logic [7:0] rx [$];
  bit nack_addr = 1'b0;

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      ps      <= 1'b1;
      pd      <= 1'b1;
      bcnt    <= 0;
      in_ack  <= 1'b0;
      ack_drv <= 1'b0;
    end else begin
      ps <= i2c_scl;
      pd <= sda_v;
      if (ps && i2c_scl && pd && !sda_v) begin
        starts  <= starts + 1;
        bcnt    <= 0;
        nbytes  <= 0;
        in_ack  <= 1'b0;
        ack_drv <= 1'b0;
      end else if (ps && i2c_scl && !pd && sda_v) begin
        stops <= stops + 1;
      end else if (!ps && i2c_scl && !in_ack && bcnt < 8) begin
        sr   <= {sr[6:0], sda_v};
        bcnt <= bcnt + 1;
      end else if (ps && !i2c_scl) begin
        if (bcnt == 8 && !in_ack) begin
          rx.push_back(sr);
          nbytes  <= nbytes + 1;
          in_ack  <= 1'b1;
          ack_drv <= !(nack_addr && nbytes == 0);
        end else if (in_ack) begin
          in_ack  <= 1'b0;
          ack_drv <= 1'b0;
          bcnt    <= 0;
        end
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic set_data(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d,
                          input logic [7:0] e);
    tx_data0 = a; tx_data1 = b; tx_data2 = c;
    tx_data3 = d; tx_data4 = e;
    exp_b[0] = a; exp_b[1] = b; exp_b[2] = c;
    exp_b[3] = d; exp_b[4] = e;
  endtask

  task automatic run_frame(input string tag, input int mid_at,
                           input int abort_at, output int cyc);
    int n;
    bit seen;
    bit aborted;
    n = 0;
    seen = 0;
    aborted = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy_rise"}, busy, 1);
    check({tag, "_ack_err_clr"}, ack_err, 0);
    while (!seen && n < 3000) begin
      @(posedge clk);
      n++;
      #1;
      start = 1'b0;
      if (done) begin
        seen = 1;
      end else if (n == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        check({tag, "_rst_scl"}, i2c_scl, 1);
        check({tag, "_rst_sda"}, sda_v, 1);
        check({tag, "_rst_busy"}, busy, 0);
        check({tag, "_rst_done"}, done, 0);
        aborted = 1;
        break;
      end else if (n == mid_at) begin
        tx_data0 = 8'h12; tx_data1 = 8'h34; tx_data2 = 8'h56;
        tx_data3 = 8'h78; tx_data4 = 8'h9a;
        start = 1'b1;
      end
    end
    if (!seen && !aborted)
      check({tag, "_done_timeout"}, 0, 1);
    if (seen)
      check({tag, "_busy_fall"}, busy, 0);
    cyc = n;
  endtask

  task automatic verify(input string tag, input int base,
                        input int s0, input int p0, input int cyc,
                        input int exp_cyc, input int nb);
    check({tag, "_done_cyc"}, cyc, exp_cyc);
    check({tag, "_nbytes"}, rx.size() - base, nb + 1);
    if (rx.size() > base)
      check({tag, "_addr"}, rx[base], 8'haa);
    for (int i = 0; i < nb; i++)
      if (rx.size() > base + 1 + i)
        check($sformatf("%s_byte%0d", tag, i), rx[base + 1 + i], exp_b[i]);
    check({tag, "_starts"}, starts - s0, 1);
    check({tag, "_stops"}, stops - p0, 1);
  endtask

  initial begin
    int cyc, base, s0, p0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_scl_hold", i2c_scl, 1);
    check("rst_busy_hold", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_scl", i2c_scl, 1);
    check("rst_sda", sda_v, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);

    // Tests 1 and 2: basic frame and bus legality
    set_data(8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
    base = rx.size(); s0 = starts; p0 = stops;
    run_frame("t1", -1, -1, cyc);
    verify("t1", base, s0, p0, cyc, FULL, 5);
    check("t1_ack_err", ack_err, 0);

    // Test 3: address NACK
    nack_addr = 1'b1;
    set_data(8'h01, 8'h80, 8'hff, 8'h00, 8'h5a);
    base = rx.size(); s0 = starts; p0 = stops;
    run_frame("t3", -1, -1, cyc);
`ifdef I2C_MASTER_ACK_CHECK_EN
    verify("t3", base, s0, p0, cyc, SHORT, 0);
    check("t3_ack_err", ack_err, 1);
`else
    verify("t3", base, s0, p0, cyc, FULL, 5);
    check("t3_ack_err", ack_err, 0);
`endif
    nack_addr = 1'b0;

    // Test 4: restart ignored mid-frame, then back-to-back frame
    set_data(8'hc3, 8'h3c, 8'h96, 8'h69, 8'he7);
    base = rx.size(); s0 = starts; p0 = stops;
    run_frame("t4a", 300, -1, cyc);
    verify("t4a", base, s0, p0, cyc, FULL, 5);
    set_data(8'h12, 8'h34, 8'h56, 8'h78, 8'h9a);
    base = rx.size(); s0 = starts; p0 = stops;
    run_frame("t4b", -1, -1, cyc);
    verify("t4b", base, s0, p0, cyc, FULL, 5);
    check("t4b_ack_err", ack_err, 0);

    // Test 5: reset during data byte 2, then a clean frame
    set_data(8'h0f, 8'hf0, 8'haa, 8'h55, 8'h33);
    run_frame("t5a", -1, 500, cyc);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    set_data(8'h81, 8'h42, 8'h24, 8'h18, 8'h7e);
    base = rx.size(); s0 = starts; p0 = stops;
    run_frame("t5b", -1, -1, cyc);
    verify("t5b", base, s0, p0, cyc, FULL, 5);
    check("t5b_ack_err", ack_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master_tx.md
# i2c_master_tx

Write-only I2C master that transmits a fixed 5-byte register frame to the right-side I2C slave at 7-bit address 0x55. It sits directly upstream of that slave on the shared SCL/SDA pair. It captures five bytes on a `start` pulse, then generates START, the address byte with write bit, five data bytes each followed by an ACK slot, and STOP. It reports completion and ACK failures to the local control logic.

## Interface
Parameters:
- `SCL_DIV`, default 250: clk cycles per quarter SCL period (phase); must be ≥ 2.
- `SLAVE_ADDR`, default 7'h55: 7-bit target address; the R/W bit is always 0.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle request; ignored while `busy`=1.
- `tx_data0`…`tx_data4` in 8 each: payload bytes, sent in order 0→4, MSB first.
- `i2c_scl` out 1: SCL, push-pull. No clock stretching is supported.
- `i2c_sda` inout 1: SDA, open-drain. Drives 0 or releases to `'z'`.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse at the end of STOP.
- `ack_err` out 1: sticky NACK flag; cleared on the next accepted `start`.

## Operation
- Reset values: `i2c_scl`=1, SDA released, `busy`=0, `done`=0, `ack_err`=0, state IDLE, phase counter 0.
- On `start` in IDLE:
  - Latch `tx_data0..4` into a 5×8 shadow.
  - Build the address byte {SLAVE_ADDR,1'b0}.
  - Set `busy`=1 and clear `ack_err`.
- Each phase lasts `SCL_DIV` clk. A phase tick advances the state machine.
- States and transitions:
  - IDLE → START on `start`.
  - START, 2 phases: first phase SDA=0 while SCL=1, second phase SCL=0. Then → ADDR.
  - ADDR / DATA: 8 bits, 4 phases each:
    - p0: SCL=0, drive the bit (release for 1, drive 0 for 0).
    - p1: SCL=1.
    - p2: SCL=1.
    - p3: SCL=0.
  - After 8 bits: ADDR → ADDR_ACK, DATA → DATA_ACK.
  - ADDR_ACK / DATA_ACK: 4 phases with SDA released. Sample the synchronized SDA on the last clk of p2; 1 means NACK.
    - After ADDR_ACK → DATA, byte index 0.
    - After DATA_ACK → DATA with the next byte, or → STOP after byte 4.
  - STOP, 3 phases:
    - SCL=0, SDA=0.
    - SCL=1, SDA=0.
    - SCL=1, SDA released.
    Then → DONE.
  - DONE, 1 clk: `done`=1, `busy`=0, → IDLE.
- SDA input is sampled through a 2-flop synchronizer before the ACK decision.
- Counters:
  - Phase counter: $clog2(SCL_DIV) bits, wraps at SCL_DIV-1.
  - Bit counter: 3 bits.
  - Byte index: 3 bits, range 0..4. Index 5 is never reached.

## Timing
- `busy` rises 1 clk after `start` is sampled high in IDLE.
- Frame length is 2 + 6·9·4 + 3 = 221 phases.
- `done` pulses at clk 221·SCL_DIV + 1 after `start` is sampled, with no NACK abort.
- SDA changes only in p0 of a bit (SCL low), except during START and STOP.
- `start` asserted while `busy`=1 or during DONE is dropped; no queueing.
- `start` and `reset` asserted together: reset wins.
- Reset mid-frame: outputs return to reset values immediately, and the frame is abandoned. The slave recovers on the next START.

## Configuration
- `I2C_MASTER_ACK_CHECK_EN` defined:
  - A NACK sets `ack_err`=1 and jumps directly to STOP at the next phase tick.
  - `done` still pulses after STOP.
- Macro undefined:
  - ACK slots are clocked but not evaluated.
  - `ack_err` is tied to 0, and all 5 bytes are always sent.

## Structure
- Package `i2c_pkg` holds:
  - the state enum (IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, DONE);
  - `I2C_NUM_BYTES`=5;
  - the default slave address 7'h55, shared with the slave side.
- Sub-module `i2c_phase_timer`: free-running divider, cleared on `start` acceptance. Outputs a one-clk `phase_tick` every `SCL_DIV` clk.

## Test plan
- Test 1: SCL_DIV=4, behavioural ACKing slave at 0x55, bytes 11,22,33,44,55.
  - Slave sees address byte AA and then the five bytes in order.
  - `done` pulses at clk 885; `ack_err`=0.
- Test 2: monitor the bus across the whole frame.
  - SDA never toggles while SCL=1, except one START (fall) and one STOP (rise).
- Test 3: slave model NACKs the address, with the macro defined.
  - `ack_err`=1, STOP follows immediately, and `done` pulses early.
  - Without the macro, all 5 bytes are sent and `ack_err`=0.
- Test 4: `start` pulsed again mid-frame with different data.
  - The pulse is ignored and the original bytes are transmitted.
  - A new `start` right after `done` clears `ack_err` and sends the new bytes.
- Test 5: assert `reset` during DATA byte 2.
  - `i2c_scl`=1, SDA=z, `busy`=0 on the next cycle.
  - A following full frame completes correctly.
